mesh_torus_router: RTL and testbench

//  5-port input-buffered router, one per node of the 2D mesh/torus network (ports 0=local,1=N,2=E,3=S,4=W).

---
 rtl/mesh_pkg.sv | 47 ++++
 rtl/mesh_router_fifo.sv | 54 +++++
 rtl/mesh_torus_router.sv | 88 ++++++++
 tb/tb_mesh_torus_router.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared packet format, port numbering and the dimension-order route decision
// used by every input of the mesh/torus router.
package mesh_pkg;

    localparam int NUM_PORTS = 5;
    localparam int LOCAL     = 0;
    localparam int NORTH     = 1;
    localparam int EAST      = 2;
    localparam int SOUTH     = 3;
    localparam int WEST      = 4;
    localparam int COORD_W   = 4;
    localparam int PAYLOAD_W = 8;

    typedef logic [2:0] port_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    typedef struct packed {
        coord_t                 dest;
        logic [PAYLOAD_W-1:0]   payload;
    } packet_t;

    localparam int PKT_W = $bits(packet_t);

    // X is resolved before Y; torus mode takes the shorter way round, ties go E/N.
    function automatic port_t route(input coord_t dest, input int x_loc, input int y_loc,
                                    input int x_nodes, input int y_nodes, input logic torus);
        int dist_x;
        int dist_y;
        dist_x = (int'(dest.x) - x_loc + x_nodes) % x_nodes;
        dist_y = (int'(dest.y) - y_loc + y_nodes) % y_nodes;
        if (torus) begin
            if (dist_x != 0) return (dist_x <= x_nodes / 2) ? port_t'(EAST) : port_t'(WEST);
            if (dist_y != 0) return (dist_y <= y_nodes / 2) ? port_t'(NORTH) : port_t'(SOUTH);
            return port_t'(LOCAL);
        end
        if (int'(dest.x) > x_loc) return port_t'(EAST);
        if (int'(dest.x) < x_loc) return port_t'(WEST);
        if (int'(dest.y) > y_loc) return port_t'(NORTH);
        if (int'(dest.y) < y_loc) return port_t'(SOUTH);
        return port_t'(LOCAL);
    endfunction

endpackage

// File: rtl/mesh_router_fifo.sv
// Per-input packet FIFO: one write, one read, combinational head and a
// registered accept enable that stays low whenever the FIFO is full.
module mesh_router_fifo
    import mesh_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  packet_t wr_data,
    input  logic    wr_val,
    output logic    wr_en,
    input  logic    rd_pop,
    output packet_t rd_data,
    output logic    rd_val
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    packet_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               push;
    logic               pop;

    assign push       = wr_val & wr_en;
    assign pop        = rd_pop & rd_val;
    assign rd_val     = (count != '0);
    assign rd_data    = mem[rd_ptr];
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // Enable looks at the post-edge occupancy, so a pop never lets a full FIFO accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_en  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            wr_en <= (count_next < CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mesh_torus_router.sv
// Five-port input-buffered router: per-input FIFO and route decode, then a
// round-robin arbiter feeding a registered output stage on each port.
module mesh_torus_router
    import mesh_pkg::*;
#(
    parameter int X_NODES    = 4,
    parameter int Y_NODES    = 4,
    parameter int X_LOC      = 0,
    parameter int Y_LOC      = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int TORUS      = 0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0][PKT_W-1:0] i_data,
    input  logic [NUM_PORTS-1:0]            i_data_val,
    output logic [NUM_PORTS-1:0]            o_en,
    output logic [NUM_PORTS-1:0][PKT_W-1:0] o_data,
    output logic [NUM_PORTS-1:0]            o_data_val,
    input  logic [NUM_PORTS-1:0]            i_en
);

    packet_t [NUM_PORTS-1:0] head;
    logic    [NUM_PORTS-1:0] head_val;
    port_t   [NUM_PORTS-1:0] route_sel;
    logic    [NUM_PORTS-1:0] pop;
    logic    [NUM_PORTS-1:0] grant_val;
    port_t   [NUM_PORTS-1:0] grant_idx;
    port_t   [NUM_PORTS-1:0] rr_ptr;

    // Input stage: buffering and route decode on each FIFO head
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        mesh_router_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_data (i_data[p]),
            .wr_val  (i_data_val[p]),
            .wr_en   (o_en[p]),
            .rd_pop  (pop[p]),
            .rd_data (head[p]),
            .rd_val  (head_val[p])
        );
        assign route_sel[p] = route(head[p].dest, X_LOC, Y_LOC, X_NODES, Y_NODES, TORUS != 0);
    end

    // Arbitration: each output searches from its pointer; a head targets one output only,
    // so at most one output can pop a given FIFO.
    always_comb begin
        int idx;
        idx       = 0;
        pop       = '0;
        grant_val = '0;
        grant_idx = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (!o_data_val[o] || i_en[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = (int'(rr_ptr[o]) + k) % NUM_PORTS;
                    if (!grant_val[o] && head_val[idx] && route_sel[idx] == port_t'(o)) begin
                        grant_val[o] = 1'b1;
                        grant_idx[o] = port_t'(idx);
                    end
                end
            end
            if (grant_val[o]) pop[grant_idx[o]] = 1'b1;
        end
    end

    // Output stage: registered packet per port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            o_data_val <= '0;
            o_data     <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (grant_val[o]) begin
                    o_data[o]     <= head[grant_idx[o]];
                    o_data_val[o] <= 1'b1;
                    rr_ptr[o]     <= (grant_idx[o] == port_t'(NUM_PORTS - 1)) ? '0
                                                                             : port_t'(grant_idx[o] + 3'd1);
                end else if (i_en[o]) begin
                    o_data_val[o] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mesh_torus_router.sv
// Bench for mesh_torus_router: a mesh router at (1,1) and a torus router at (0,0),
// directed vectors and sequences plus randomized traffic against a scoreboard.
module tb_mesh_torus_router;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [1:0][4:0][15:0]  idata;
    logic [1:0][4:0]        ival;
    logic [1:0][4:0]        oen;
    logic [1:0][4:0][15:0]  odata;
    logic [1:0][4:0]        oval;
    logic [1:0][4:0]        ien;

    int n_pass = 0;
    int n_total = 0;
    int delivered = 0;
    bit sb_on = 1'b0;
    logic [15:0] sbq [50][$];

    always #5 clk = ~clk;

    mesh_torus_router #(.X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(1), .FIFO_DEPTH(4), .TORUS(0)) u_mesh (
        .clk(clk), .reset_n(reset_n), .i_data(idata[0]), .i_data_val(ival[0]), .o_en(oen[0]),
        .o_data(odata[0]), .o_data_val(oval[0]), .i_en(ien[0]));

    mesh_torus_router #(.X_NODES(4), .Y_NODES(4), .X_LOC(0), .Y_LOC(0), .FIFO_DEPTH(4), .TORUS(1)) u_torus (
        .clk(clk), .reset_n(reset_n), .i_data(idata[1]), .i_data_val(ival[1]), .o_en(oen[1]),
        .o_data(odata[1]), .o_data_val(oval[1]), .i_en(ien[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] mk(input int x, input int y, input int src, input int seq);
        return {4'(x), 4'(y), 3'(src), 5'(seq)};
    endfunction

    // Reference routing: mesh goes toward the destination, torus picks the fewer-hop direction.
    function automatic int ref_route(input int d, input int dx, input int dy);
        int lx, ly, fwd, bwd;
        lx = (d == 0) ? 1 : 0;
        ly = (d == 0) ? 1 : 0;
        if (d == 0) begin
            if (dx != lx) return (dx > lx) ? 2 : 4;
            if (dy != ly) return (dy > ly) ? 1 : 3;
            return 0;
        end
        fwd = (dx - lx + 4) % 4;
        bwd = (lx - dx + 4) % 4;
        if (fwd != 0) return (fwd <= bwd) ? 2 : 4;
        fwd = (dy - ly + 4) % 4;
        bwd = (ly - dy + 4) % 4;
        if (fwd != 0) return (fwd <= bwd) ? 1 : 3;
        return 0;
    endfunction

    function automatic int rr_next(input int s);
        case (s)
            0: return 1;
            1: return 3;
            3: return 4;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin : mon
        int s, key;
        logic [15:0] e;
        if (sb_on) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 5; p++) begin
                    if (oval[d][p] && ien[d][p]) begin
                        s = int'(odata[d][p][7:5]);
                        key = d * 25 + p * 5 + s;
                        if (s < 5 && sbq[key].size() > 0) e = sbq[key].pop_front();
                        else e = ~odata[d][p];
                        chk($sformatf("sb_pkt d%0d p%0d", d, p), 32'(odata[d][p]), 32'(e));
                        delivered++;
                    end
                    if (ival[d][p] && oen[d][p]) begin
                        key = d * 25 + ref_route(d, int'(idata[d][p][15:12]), int'(idata[d][p][11:8])) * 5 + p;
                        sbq[key].push_back(idata[d][p]);
                    end
                end
            end
        end
    end

    typedef struct {
        int d;
        int src;
        int x;
        int y;
        int port;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int prev, cur, remain, seq;
        logic [15:0] pk;
        ival = '0; idata = '0; ien = '1;

        // Reset state and o_en timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oen", 32'(oen), 32'h0);
        chk("rst_oval", 32'(oval), 32'h0);
        chk("rst_odata", 32'(|odata), 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk); chk("oen_before_edge", 32'(oen), 32'h0);
        @(negedge clk); chk("oen_after_edge", 32'(oen), 32'h3ff);

        // Reset with packets buffered
        ien[0] = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 ival[0][0] = 1'b1; idata[0][0] = mk(3, 1, 0, k);
        end
        @(negedge clk); chk("queued_oval", 32'(oval[0][2]), 32'h1);
        @(posedge clk); #1 ival = '0; reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_oval", 32'(oval), 32'h0);
        chk("midrst_oen", 32'(oen), 32'h0);
        chk("midrst_odata", 32'(|odata), 32'h0);
        @(posedge clk); #1 reset_n = 1'b1; ien = '1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("rst_discard", 32'(oval), 32'h0);
        end

        // Routing vectors: one packet each, output expected one edge after acceptance
        vecs[0]  = '{0, 0, 3, 1, 2};
        vecs[1]  = '{0, 0, 1, 0, 3};
        vecs[2]  = '{0, 0, 1, 1, 0};
        vecs[3]  = '{0, 1, 0, 3, 4};
        vecs[4]  = '{0, 2, 1, 3, 1};
        vecs[5]  = '{0, 4, 2, 0, 2};
        vecs[6]  = '{0, 3, 0, 0, 4};
        vecs[7]  = '{1, 0, 3, 0, 4};
        vecs[8]  = '{1, 0, 2, 0, 2};
        vecs[9]  = '{1, 0, 0, 3, 3};
        vecs[10] = '{1, 0, 0, 2, 1};
        vecs[11] = '{1, 1, 1, 3, 2};
        vecs[12] = '{1, 3, 0, 1, 1};
        vecs[13] = '{1, 2, 0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            pk = mk(vecs[i].x, vecs[i].y, vecs[i].src, i);
            @(posedge clk); #1 ival[vecs[i].d][vecs[i].src] = 1'b1; idata[vecs[i].d][vecs[i].src] = pk;
            @(posedge clk); #1 ival = '0;
            @(negedge clk); chk($sformatf("vec%0d_lat0", i), 32'(oval[vecs[i].d]), 32'h0);
            @(negedge clk);
            chk($sformatf("vec%0d_port", i), 32'(oval[vecs[i].d]), 32'(1 << vecs[i].port));
            chk($sformatf("vec%0d_data", i), 32'(odata[vecs[i].d][vecs[i].port]), 32'(pk));
        end

        // Backpressure: E blocked, five packets from W input
        @(posedge clk); #1 ien[0] = 5'b11011;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 ival[0][4] = 1'b1; idata[0][4] = mk(3, 1, 4, k);
            @(negedge clk); chk($sformatf("bp_oen_%0d", k), 32'(oen[0][4]), 32'h1);
        end
        @(posedge clk); #1 ival = '0;
        @(negedge clk);
        chk("bp_full_oen", 32'(oen[0][4]), 32'h0);
        chk("bp_hold_val", 32'(oval[0][2]), 32'h1);
        chk("bp_hold_data", 32'(odata[0][2]), 32'(mk(3, 1, 4, 0)));
        ien[0] = '1;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_drain_val%0d", k), 32'(oval[0][2]), 32'h1);
            chk($sformatf("bp_drain_data%0d", k), 32'(odata[0][2]), 32'(mk(3, 1, 4, k)));
            if (k == 1) chk("bp_oen_back", 32'(oen[0][4]), 32'h1);
        end
        @(negedge clk); chk("bp_empty", 32'(oval[0][2]), 32'h0);

        // Four inputs contend for E: strict rotation 0,1,3,4
        @(posedge clk); #1;
        ival[0] = 5'b11011;
        idata[0][0] = mk(3, 1, 0, 0);
        idata[0][1] = mk(3, 3, 1, 0);
        idata[0][3] = mk(3, 0, 3, 0);
        idata[0][4] = mk(2, 1, 4, 0);
        repeat (4) @(negedge clk);
        prev = int'(odata[0][2][7:5]);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            cur = int'(odata[0][2][7:5]);
            chk($sformatf("rr_val%0d", k), 32'(oval[0][2]), 32'h1);
            chk($sformatf("rr_order%0d", k), 32'(cur), 32'(rr_next(prev)));
            prev = cur;
        end
        @(posedge clk); #1 ival = '0;
        repeat (25) @(posedge clk);

        // All five inputs to distinct outputs, full rate
        #1 sb_on = 1'b1;
        seq = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            ival[0] = '1;
            idata[0][0] = mk(3, 1, 0, seq);
            idata[0][1] = mk(1, 0, 1, seq);
            idata[0][2] = mk(0, 1, 2, seq);
            idata[0][3] = mk(1, 3, 3, seq);
            idata[0][4] = mk(1, 1, 4, seq);
            seq++;
            if (k >= 3) begin
                @(negedge clk);
                chk($sformatf("par_oval%0d", k), 32'(oval[0]), 32'h1f);
                chk($sformatf("par_oen%0d", k), 32'(oen[0]), 32'h1f);
            end
        end
        @(posedge clk); #1 ival = '0;
        repeat (6) @(posedge clk);

        // Randomized traffic on both routers
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 5; p++) begin
                    ival[d][p] = 1'($urandom_range(0, 1));
                    idata[d][p] = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), p, seq);
                    ien[d][p] = ($urandom_range(0, 3) != 0);
                end
            end
            seq++;
        end
        @(posedge clk); #1 ival = '0; ien = '1;
        repeat (40) @(posedge clk);
        #1 sb_on = 1'b0;
        remain = 0;
        for (int i = 0; i < 50; i++) remain += sbq[i].size();
        chk("sb_drained", 32'(remain), 32'h0);
        chk("sb_delivered", 32'(delivered > 200), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
